// File: rtl/boot_sequencer_if.sv
// Loader write port, CPU fetch port and program-memory port.
// slave is the sequencer side; master is the environment side.
interface boot_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  cpu_req, cpu_addr, mem_rdata,
    output ld_ready, cpu_ack, cpu_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_valid, ld_addr, ld_data,
    output cpu_req, cpu_addr, mem_rdata,
    input  ld_ready, cpu_ack, cpu_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot/load/run sequencer owning the program-memory port.
// Define SINGLE_STEP_EN for the debounced manual step button.
module boot_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STEP_DIV     = 5000000,
  parameter int LOAD_TIMEOUT = 2700000,
  parameter int RST_HOLD     = 16
) (
  input  logic              clk,
  input  logic              reset,
  boot_sequencer_if.slave   bus,
  output logic              cpu_reset,
  output logic              cpu_enable,
  output logic              cpu_step,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_count
`ifdef SINGLE_STEP_EN
  ,
  input  logic              step_mode,
  input  logic              step_btn
`endif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int IW = $clog2(LOAD_TIMEOUT + 1);
  localparam int SW = $clog2(STEP_DIV + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(LOAD_TIMEOUT - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            st_q, st_d;
  logic [HW-1:0]     hold_q;
  logic [IW-1:0]     idle_q;
  logic [SW-1:0]     step_q;
  logic              step_o;
  logic              pend_q;
  logic [DATA_W-1:0] rdata_q;

  logic ld_ok;
  logic run;
  logic wr;
  logic issue;
  logic abort;
  logic ack;
  logic manual;
  logic btn_rise;

`ifdef SINGLE_STEP_EN
  logic [1:0]  sync_q;
  logic        db_q;
  logic        db_prev_q;
  logic [15:0] db_cnt_q;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], step_btn};
  end

  // Accept a new button level only after 2^16 stable cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      db_prev_q <= db_q;
      if (sync_q[1] == db_q) begin
        db_cnt_q <= '0;
      end else if (&db_cnt_q) begin
        db_q     <= sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 16'd1;
      end
    end
  end

  assign manual   = step_mode;
  assign btn_rise = db_q & ~db_prev_q;
`else
  assign manual   = 1'b0;
  assign btn_rise = 1'b0;
`endif

  // Next state and memory-port arbitration.
  always_comb begin
    st_d  = st_q;
    ld_ok = 1'b0;
    run   = 1'b0;
    issue = 1'b0;
    unique case (st_q)
      S_BOOT: begin
        if (hold_q == HOLD_LAST) st_d = S_WAIT;
      end
      S_WAIT: begin
        ld_ok = 1'b1;
        if (bus.ld_valid) st_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ok = 1'b1;
        if (!bus.ld_valid && idle_q == IDLE_LAST)
          st_d = S_RUN;
      end
      S_RUN: begin
        run   = 1'b1;
        issue = bus.cpu_req & ~pend_q;
        if (bus.ld_valid) st_d = S_LOAD;
      end
      default: st_d = S_BOOT;
    endcase
  end

  assign wr    = bus.ld_valid & ld_ok;
  assign abort = run & bus.ld_valid;
  assign ack   = run & pend_q & ~bus.ld_valid;

  // Writes win the port; a fetch address is only driven in RUN.
  always_comb begin
    bus.mem_we    = wr;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (wr) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_data;
    end else if (issue) begin
      bus.mem_addr  = bus.cpu_addr;
    end
  end

  assign bus.ld_ready  = ld_ok;
  assign bus.cpu_ack   = ack;
  assign bus.cpu_rdata = ack ? bus.mem_rdata : rdata_q;
  assign cpu_reset     = ~run;
  assign cpu_enable    = run;
  assign cpu_step      = step_o;
  assign state         = st_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= S_BOOT;
    else       st_q <= st_d;
  end

  // Reset-hold counter while in BOOT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hold_q <= '0;
    else if (st_q == S_BOOT && hold_q != HOLD_LAST)
      hold_q <= hold_q + HW'(1);
  end

  // Idle counter: cleared outside LOAD and by every write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_q <= '0;
    else if (st_q != S_LOAD || wr)
      idle_q <= '0;
    else if (idle_q != IDLE_LAST)
      idle_q <= idle_q + IW'(1);
  end

  // Saturating count of words in the current load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      load_count <= '0;
    else if (abort)
      load_count <= '0;
    else if (wr && load_count != CNT_MAX)
      load_count <= load_count + CNT_ONE;
  end

  // One read in flight; hold the last fetched word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q <= issue;
      if (ack) rdata_q <= bus.mem_rdata;
    end
  end

  // Step strobe: free-running divider or debounced button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0;
      step_o <= 1'b0;
    end else if (!run || abort) begin
      step_q <= '0;
      step_o <= 1'b0;
    end else if (manual) begin
      step_q <= '0;
      step_o <= btn_rise;
    end else if (step_q == STEP_LAST) begin
      step_q <= '0;
      step_o <= 1'b1;
    end else begin
      step_q <= step_q + SW'(1);
      step_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: table load, hand sequences,
// random loads and fetches against an address-level model.
module tb_boot_sequencer;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SDIV = 10;
  localparam int TMO  = 100;
  localparam int HOLD = 16;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] WAITS = 2'd1;
  localparam logic [1:0] LOADS = 2'd2;
  localparam logic [1:0] RUNS  = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_reset, cpu_enable, cpu_step;
  logic [1:0] state;
  logic [AW:0] load_count;
`ifdef SINGLE_STEP_EN
  logic step_mode = 1'b0;
  logic step_btn = 1'b0;
`endif

  boot_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  boot_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .STEP_DIV(SDIV),
    .LOAD_TIMEOUT(TMO), .RST_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .cpu_enable(cpu_enable),
    .cpu_step(cpu_step),
    .state(state),
    .load_count(load_count)
`ifdef SINGLE_STEP_EN
    ,
    .step_mode(step_mode),
    .step_btn(step_btn)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port program memory.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic        vld;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  st;
    int          cnt;
  } vec_t;

  vec_t tbl [4];
  logic [DW-1:0] ref_mem [256];
  bit ref_ok [256];
  int n_chk = 0;
  int n_err = 0;
  int cnt, gap, age;
  bit req;
  logic [7:0] addr, fa;
  logic [31:0] data;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_state"}, state, BOOT);
    chk({t, "_cpu_reset"}, cpu_reset, 1);
    chk({t, "_enable"}, cpu_enable, 0);
    chk({t, "_step"}, cpu_step, 0);
    chk({t, "_ld_ready"}, bus.ld_ready, 0);
    chk({t, "_ack"}, bus.cpu_ack, 0);
    chk({t, "_we"}, bus.mem_we, 0);
    chk({t, "_maddr"}, bus.mem_addr, 0);
    chk({t, "_wdata"}, bus.mem_wdata, 0);
    chk({t, "_rdata"}, bus.cpu_rdata, 0);
    chk({t, "_count"}, load_count, 0);
  endtask

  initial begin
    bus.ld_valid = 0;
    bus.ld_addr  = 0;
    bus.ld_data  = 0;
    bus.cpu_req  = 0;
    bus.cpu_addr = 0;
    for (int i = 0; i < 256; i++) ref_ok[i] = 0;

    tbl[0] = '{1'b1, 8'd0, 32'h00500093, WAITS, 0};
    tbl[1] = '{1'b1, 8'd1, 32'h00108113, LOADS, 1};
    tbl[2] = '{1'b1, 8'd2, 32'h0000006F, LOADS, 2};
    tbl[3] = '{1'b0, 8'd0, 32'h00000000, LOADS, 3};

    #2 reset = 1'b1;
    #1 chk_reset("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // BOOT hold, ignoring a loader that asks too early
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      bus.ld_valid = (k >= 4 && k < 7);
      #1;
      chk("boot_state", state, (k < HOLD) ? BOOT : WAITS);
      chk("boot_rst", cpu_reset, 1);
      chk("boot_rdy", bus.ld_ready, k >= HOLD);
      chk("boot_we", bus.mem_we, 0);
    end

    // Three-word program from the table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ld_valid = tbl[i].vld;
      bus.ld_addr  = tbl[i].addr;
      bus.ld_data  = tbl[i].data;
      #1;
      chk("tbl_we", bus.mem_we, tbl[i].vld);
      chk("tbl_addr", bus.mem_addr,
          tbl[i].vld ? tbl[i].addr : 8'd0);
      chk("tbl_wdata", bus.mem_wdata,
          tbl[i].vld ? tbl[i].data : 32'd0);
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_count", load_count, tbl[i].cnt);
      chk("tbl_rst", cpu_reset, 1);
      if (tbl[i].vld) begin
        ref_mem[tbl[i].addr] = tbl[i].data;
        ref_ok[tbl[i].addr] = 1;
      end
    end

    // Idle timeout ends LOAD
    for (int j = 1; j <= TMO; j++) begin
      @(negedge clk);
      #1;
      chk("tmo_state", state, (j < TMO) ? LOADS : RUNS);
    end
    chk("run_rst", cpu_reset, 0);
    chk("run_en", cpu_enable, 1);
    chk("run_step0", cpu_step, 0);
    chk("run_rdy", bus.ld_ready, 0);

    // Step strobe every SDIV cycles from RUN entry
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      #1;
      chk("step", cpu_step, (k % SDIV) == 0);
    end

    // Single fetch, then a held request
    @(negedge clk);
    bus.cpu_req = 1;
    bus.cpu_addr = 8'd1;
    #1;
    chk("f0_addr", bus.mem_addr, 1);
    chk("f0_ack", bus.cpu_ack, 0);
    chk("f0_we", bus.mem_we, 0);
    @(negedge clk);
    #1;
    chk("f1_ack", bus.cpu_ack, 1);
    chk("f1_data", bus.cpu_rdata, 32'h00108113);
    @(negedge clk);
    #1;
    chk("f2_ack", bus.cpu_ack, 0);
    chk("f2_addr", bus.mem_addr, 1);
    @(negedge clk);
    #1;
    chk("f3_ack", bus.cpu_ack, 1);
    chk("f3_data", bus.cpu_rdata, 32'h00108113);
    @(negedge clk);
    bus.cpu_req = 0;
    #1;
    chk("f4_ack", bus.cpu_ack, 0);

    // Loader aborts RUN with a fetch outstanding
    @(negedge clk);
    bus.cpu_req = 1;
    bus.cpu_addr = 8'd2;
    #1;
    chk("ab_issue", bus.mem_addr, 2);
    @(negedge clk);
    bus.ld_valid = 1;
    bus.ld_addr = 8'd5;
    bus.ld_data = 32'hDEADBEEF;
    #1;
    chk("ab_noack", bus.cpu_ack, 0);
    chk("ab_rdy", bus.ld_ready, 0);
    chk("ab_we", bus.mem_we, 0);
    chk("ab_state", state, RUNS);
    @(negedge clk);
    bus.cpu_req = 0;
    #1;
    chk("ab_load", state, LOADS);
    chk("ab_rst", cpu_reset, 1);
    chk("ab_count", load_count, 0);
    chk("ab_wr", bus.mem_we, 1);
    chk("ab_waddr", bus.mem_addr, 5);
    chk("ab_ack2", bus.cpu_ack, 0);
    ref_mem[5] = 32'hDEADBEEF;
    ref_ok[5] = 1;
    @(negedge clk);
    bus.ld_valid = 0;
    #1;
    chk("ab_count1", load_count, 1);

    // Random writes, count saturates at 256
    cnt = 1;
    for (int w = 0; w < 300; w++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g <= gap; g++) begin
        @(negedge clk);
        bus.ld_valid = (g == gap);
        if (g == gap) begin
          addr = 8'($urandom);
          data = $urandom;
          bus.ld_addr = addr;
          bus.ld_data = data;
        end
        #1;
        chk("rl_count", load_count, (cnt > 256) ? 256 : cnt);
        chk("rl_we", bus.mem_we, g == gap);
        if (g == gap) begin
          chk("rl_addr", bus.mem_addr, addr);
          ref_mem[addr] = data;
          ref_ok[addr] = 1;
          cnt++;
        end
      end
    end
    for (int j = 1; j <= TMO + 1; j++) begin
      @(negedge clk);
      bus.ld_valid = 0;
      #1;
      chk("rl_tmo", state, (j <= TMO) ? LOADS : RUNS);
    end

    // Random fetches: each request acked one cycle after issue
    req = 0;
    age = 0;
    fa = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!req && $urandom_range(0, 1) == 1) begin
        req = 1;
        fa = 8'($urandom);
        age = 0;
      end
      bus.cpu_req = req;
      bus.cpu_addr = fa;
      #1;
      chk("rf_ack", bus.cpu_ack, req && age == 1);
      if (req && age == 0) chk("rf_addr", bus.mem_addr, fa);
      if (req && age == 1) begin
        if (ref_ok[fa])
          chk("rf_data", bus.cpu_rdata, ref_mem[fa]);
        req = 0;
      end else if (req) begin
        age++;
      end
    end

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    bus.cpu_req = 0;
    bus.ld_valid = 1;
    bus.ld_addr = 8'h09;
    bus.ld_data = 32'h12345678;
    #1;
    chk("mid_run", state, RUNS);
    @(negedge clk);
    #1;
    chk("mid_load", state, LOADS);
    chk("mid_we", bus.mem_we, 1);
    #2;
    reset = 1'b1;
    bus.cpu_req = 1;
    #1;
    chk_reset("mid");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
